seq_multiplier: RTL
===================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; product width is 2*WIDTH.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  level request from the ALU; sampled on rising edge of clock.
REQ-005 mult1  input  WIDTH  unsigned multiplicand.
REQ-006 mult2  input  WIDTH  unsigned multiplier.
REQ-007 done  output  1  registered; high while produto holds a completed result not yet superseded by an accepted request.
REQ-008 busy  output  1  registered; high while an iteration is in progress.
REQ-009 produto  output  2*WIDTH  registered unsigned product of the last completed request.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, BUSY and DONE; illegal encodings SHALL return to IDLE on the next edge.
REQ-011 IDLE: start=1 at an edge -> latch mult1/mult2 into internal registers, clear accumulator, load iteration counter with WIDTH, go to BUSY; start=0 -> remain in IDLE.
REQ-012 BUSY: each edge SHALL examine the LSB of the shifted multiplier; if 1, add the shifted multiplicand into the 2*WIDTH accumulator; then shift multiplicand left 1, shift multiplier right 1, decrement counter.
REQ-013 BUSY SHALL last exactly WIDTH edges regardless of operand values, including zero operands; there is no early termination.
REQ-014 On the WIDTH-th BUSY edge: produto <= final accumulator, done <= 1, busy <= 0, state -> DONE.
REQ-015 Latency: with start accepted at edge E, done and produto are valid after edge E+WIDTH (16 cycles for the default).
REQ-016 DONE: start=1 at an edge -> treat as a new request exactly as in IDLE, with done <= 0 and busy <= 1 on that same edge; start=0 -> go to IDLE with done held at 1.
REQ-017 IDLE entered from DONE SHALL keep done=1 and produto unchanged until the next accepted start.
REQ-018 done SHALL fall only on the edge that accepts a new request, or on reset.
REQ-019 start and mult1/mult2 changes during BUSY SHALL be ignored; the computation SHALL use the operands latched at acceptance.
REQ-020 produto SHALL change only on a completion edge (REQ-014) or on reset; it SHALL NOT show partial sums.
REQ-021 Arithmetic SHALL be unsigned; the accumulator SHALL be 2*WIDTH bits and cannot overflow (max 0xFFFF*0xFFFF = 0xFFFE0001 for WIDTH=16).
REQ-022 busy and done SHALL never be high simultaneously.

Reset
REQ-023 reset=1 SHALL immediately, without waiting for a clock edge, force state IDLE, done=0, busy=0, produto=0, and clear the accumulator, counter and operand registers.
REQ-024 reset asserted during BUSY SHALL abort the operation; no result from the aborted request SHALL ever appear on produto.
REQ-025 After reset deasserts, the first edge with start=1 SHALL be accepted as a new request per REQ-011.

Verification
REQ-026 Basic: reset, then mult1=3, mult2=5, start=1 held -> busy high for 16 cycles, then done=1 with produto=15 (0x0000000F) after edge E+16.
REQ-027 Extremes: 0xFFFF*0xFFFF -> produto=0xFFFE0001; 0x0000*0x1234 -> produto=0 after the full 16 cycles, with no early done.
REQ-028 Operand change mid-run: accept 7*9, change mult1 to 100 at cycle 5 -> produto=63; start deasserted after done -> IDLE, done stays 1, produto stays 63.
REQ-029 Back-to-back: after 2*3 completes, keep start=1 with new operands 0x0100*0x0100 -> done drops on the next edge, busy rises, and 16 cycles later produto=0x00010000.
REQ-030 Reset mid-operation: accept 0x00FF*0x00FF, assert reset at cycle 8 between clock edges -> done=0, busy=0, produto=0 immediately; release reset, request 2*2 -> produto=4 after 16 cycles, and 0xFE01 never appears.

Source files
------------

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add unsigned multiplier: one multiplier bit per clock,
// WIDTH iterations per request, with a registered IDLE/BUSY/DONE handshake.
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mult1,
  input  logic [WIDTH-1:0]     mult2,
  output logic                 done,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   produto
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [CNT_W-1:0]     cnt;

  // Partial-product add for the current multiplier LSB; 2*WIDTH bits cannot overflow.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      done    <= 1'b0;
      busy    <= 1'b0;
      produto <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // DONE behaves like IDLE for acceptance; done stays up until a new request.
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, mult1};
            mplier <= mult2;
            acc    <= '0;
            cnt    <= CNT_W'(WIDTH);
            busy   <= 1'b1;
            done   <= 1'b0;
            state  <= BUSY;
          end else begin
            state  <= IDLE;
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            produto <= acc_next;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
